dmem_arbiter: RTL and testbench

Two-master arbiter sharing the single CPU data-side port of the system bus (address, write data, write enable, read data) between the CPU load/store unit (master 0) and a UART boot/DMA loader (master 1). Sits between the masters and the bus's cpu_dmem_* inputs. Serialises accesses with a req/ack handshake, provides round-robin fairness, and returns read data with a valid strobe after a configurable memory read latency.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter_rr_arb2.sv | 19 +
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encodings,
// master indices and counter sizing.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam int M_CPU     = 0;
  localparam int M_LOADER  = 1;
  localparam int N_MASTERS = 2;
  localparam int CNT_W     = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both master request/response ports plus the system-bus side.
// The arbiter takes the slave view; the masters/bus model take the master view.
interface dmem_arbiter_if;

  logic        m0_req,    m1_req;
  logic [31:0] m0_addr,   m1_addr;
  logic [31:0] m0_wdata,  m1_wdata;
  logic        m0_wen,    m1_wen;
  logic        m0_ack,    m1_ack;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata,  m1_rdata;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic [31:0] bus_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_wen,
    input  m1_req, m1_addr, m1_wdata, m1_wen,
    output m0_ack, m0_rvalid, m0_rdata,
    output m1_ack, m1_rvalid, m1_rdata,
    output bus_addr, bus_wdata, bus_wen,
    input  bus_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_wen,
    output m1_req, m1_addr, m1_wdata, m1_wen,
    input  m0_ack, m0_rvalid, m0_rdata,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  bus_addr, bus_wdata, bus_wen,
    output bus_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the master not served last wins.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = '0;
      if (last == 1'(M_LOADER)) grant[M_CPU]    = 1'b1;
      else                      grant[M_LOADER] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and loader accesses onto the single data-side bus port,
// returning read data with a valid strobe after RD_LAT cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  port
);

  logic [N_MASTERS-1:0] req;
  logic [31:0]          addr  [N_MASTERS];
  logic [31:0]          wdata [N_MASTERS];
  logic [N_MASTERS-1:0] wen;
  logic [N_MASTERS-1:0] grant;
  logic                 gnt_idx;

  arb_state_t           state_reg;
  logic                 owner_reg;
  logic                 last_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [N_MASTERS-1:0] ack_reg;
  logic [N_MASTERS-1:0] rvalid_reg;
  logic [31:0]          rdata_reg [N_MASTERS];
  logic [31:0]          bus_addr_reg;
  logic [31:0]          bus_wdata_reg;
  logic                 bus_wen_reg;

  assign req[M_CPU]      = port.m0_req;
  assign req[M_LOADER]   = port.m1_req;
  assign addr[M_CPU]     = port.m0_addr;
  assign addr[M_LOADER]  = port.m1_addr;
  assign wdata[M_CPU]    = port.m0_wdata;
  assign wdata[M_LOADER] = port.m1_wdata;
  assign wen[M_CPU]      = port.m0_wen;
  assign wen[M_LOADER]   = port.m1_wen;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_reg),
    .grant (grant)
  );

  assign gnt_idx = grant[M_LOADER];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      cnt_reg       <= '0;
      ack_reg       <= '0;
      rvalid_reg    <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_wen_reg   <= 1'b0;
      for (int i = 0; i < N_MASTERS; i++) rdata_reg[i] <= '0;
    end else begin
      // Pulses and bus drive default low; only ISSUE/WAIT hold the bus.
      ack_reg       <= '0;
      rvalid_reg    <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_wen_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            owner_reg     <= gnt_idx;
            last_reg      <= gnt_idx;
            ack_reg       <= grant;
            bus_addr_reg  <= addr[gnt_idx];
            bus_wdata_reg <= wdata[gnt_idx];
            bus_wen_reg   <= wen[gnt_idx];
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // bus_wen_reg is high during ISSUE exactly when this access is a write.
          if (bus_wen_reg) begin
            state_reg <= ST_IDLE;
          end else if (RD_LAT == 0) begin
            rdata_reg[owner_reg]  <= port.bus_rdata;
            rvalid_reg[owner_reg] <= 1'b1;
            state_reg             <= ST_IDLE;
          end else begin
            cnt_reg       <= CNT_W'(RD_LAT);
            bus_addr_reg  <= bus_addr_reg;
            bus_wdata_reg <= bus_wdata_reg;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            rdata_reg[owner_reg]  <= port.bus_rdata;
            rvalid_reg[owner_reg] <= 1'b1;
            cnt_reg               <= '0;
            state_reg             <= ST_IDLE;
          end else begin
            cnt_reg       <= cnt_reg - CNT_W'(1);
            bus_addr_reg  <= bus_addr_reg;
            bus_wdata_reg <= bus_wdata_reg;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign port.m0_ack    = ack_reg[M_CPU];
  assign port.m1_ack    = ack_reg[M_LOADER];
  assign port.m0_rvalid = rvalid_reg[M_CPU];
  assign port.m1_rvalid = rvalid_reg[M_LOADER];
  assign port.m0_rdata  = rdata_reg[M_CPU];
  assign port.m1_rdata  = rdata_reg[M_LOADER];
  assign port.bus_addr  = bus_addr_reg;
  assign port.bus_wdata = bus_wdata_reg;
  assign port.bus_wen   = bus_wen_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed master traffic, expected
// ack/rvalid events queued with hand-computed cycles and checked by a monitor.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if ifc ();

  dmem_arbiter #(.RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port  (ifc)
  );

  typedef struct {
    int          start;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
  } op_t;

  typedef struct {
    int          cyc;
    int          m;
    bit          rv;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] rdata;
  } exp_t;

  op_t  mq [2][$];
  exp_t sb [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        req_d   [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic        wen_d   [2];
  logic [31:0] rdata_d;
  logic        ack_v   [2];
  logic        rv_v    [2];
  logic [31:0] rdata_v [2];

  assign ifc.m0_req    = req_d[0];
  assign ifc.m1_req    = req_d[1];
  assign ifc.m0_addr   = addr_d[0];
  assign ifc.m1_addr   = addr_d[1];
  assign ifc.m0_wdata  = wdata_d[0];
  assign ifc.m1_wdata  = wdata_d[1];
  assign ifc.m0_wen    = wen_d[0];
  assign ifc.m1_wen    = wen_d[1];
  assign ifc.bus_rdata = rdata_d;
  assign ack_v[0]      = ifc.m0_ack;
  assign ack_v[1]      = ifc.m1_ack;
  assign rv_v[0]       = ifc.m0_rvalid;
  assign rv_v[1]       = ifc.m1_rvalid;
  assign rdata_v[0]    = ifc.m0_rdata;
  assign rdata_v[1]    = ifc.m1_rdata;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h1000_0008) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_op(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input int start);
    op_t o;
    o.start = start; o.addr = a; o.wdata = d; o.wen = w;
    mq[m].push_back(o);
  endtask

  task automatic exp_ack(input int c, input int m, input logic [31:0] a,
                         input logic [31:0] d, input logic w);
    exp_t e;
    e.cyc = c; e.m = m; e.rv = 1'b0; e.addr = a; e.wdata = d; e.wen = w; e.rdata = '0;
    sb.push_back(e);
  endtask

  task automatic exp_rv(input int c, input int m, input logic [31:0] r);
    exp_t e;
    e.cyc = c; e.m = m; e.rv = 1'b1; e.addr = '0; e.wdata = '0; e.wen = 1'b0; e.rdata = r;
    sb.push_back(e);
  endtask

  initial forever @(posedge clk) cyc++;

  // Master drivers and bus model: read data appears only in the cycle after ISSUE.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    pend = 1'b0;
    pend_addr = '0;
    rdata_d = 32'hDEAD_0000;
    for (int m = 0; m < 2; m++) begin
      req_d[m] = 1'b0; addr_d[m] = '0; wdata_d[m] = '0; wen_d[m] = 1'b0;
    end
    forever begin
      @(negedge clk);
      rdata_d   = pend ? mem_data(pend_addr) : (32'hDEAD_0000 | 32'(cyc[15:0]));
      pend      = (ifc.m0_ack | ifc.m1_ack) & ~ifc.bus_wen;
      pend_addr = ifc.bus_addr;
      for (int m = 0; m < 2; m++) begin
        if (req_d[m] && ack_v[m]) begin
          void'(mq[m].pop_front());
          req_d[m] = 1'b0;
        end
        if (!req_d[m] && mq[m].size() > 0 && mq[m][0].start <= cyc) begin
          addr_d[m]  = mq[m][0].addr;
          wdata_d[m] = mq[m][0].wdata;
          wen_d[m]   = mq[m][0].wen;
          req_d[m]   = 1'b1;
        end
      end
    end
  end

  task automatic check_pulse(input int m, input bit rv, input logic [31:0] r_act);
    exp_t e;
    bit   ok;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s m%0d cyc %0d: got pulse, expected none",
               rv ? "rvalid" : "ack", m, cyc);
      return;
    end
    e = sb.pop_front();
    if (rv)
      ok = e.rv && e.m == m && e.cyc == cyc && e.rdata == r_act;
    else
      ok = !e.rv && e.m == m && e.cyc == cyc && e.addr == ifc.bus_addr &&
           e.wdata == ifc.bus_wdata && e.wen == ifc.bus_wen;
    if (!ok) begin
      errors++;
      $display("FAIL %s_m%0d: got cyc %0d addr %h wdata %h wen %0b rdata %h, need %s m%0d cyc %0d addr %h wdata %h wen %0b rdata %h",
               rv ? "rvalid" : "ack", m, cyc, ifc.bus_addr, ifc.bus_wdata, ifc.bus_wen, r_act,
               e.rv ? "rvalid" : "ack", e.m, e.cyc, e.addr, e.wdata, e.wen, e.rdata);
    end else if (rv) begin
      $display("ok   rvalid m%0d cyc %0d rdata %h", m, cyc, r_act);
    end else begin
      $display("ok   ack    m%0d cyc %0d addr %h wdata %h wen %0b",
               m, cyc, ifc.bus_addr, ifc.bus_wdata, ifc.bus_wen);
    end
  endtask

  initial forever begin
    @(negedge clk);
    checks++;
    if (ifc.bus_wen && !(ifc.m0_ack || ifc.m1_ack)) begin
      errors++;
      $display("FAIL spurious_wen cyc %0d: got bus_wen 1 without ack, need 0", cyc);
    end
    for (int m = 0; m < 2; m++) begin
      if (ack_v[m]) check_pulse(m, 1'b0, '0);
      if (rv_v[m])  check_pulse(m, 1'b1, rdata_v[m]);
    end
  end

  task automatic check_reset_outputs();
    checks++;
    if (ifc.m0_ack || ifc.m1_ack || ifc.m0_rvalid || ifc.m1_rvalid || ifc.bus_wen ||
        ifc.bus_addr != 0 || ifc.bus_wdata != 0 || ifc.m0_rdata != 0 || ifc.m1_rdata != 0) begin
      errors++;
      $display("FAIL reset_outputs cyc %0d: got ack %0b%0b rv %0b%0b wen %0b addr %h wdata %h rdata %h %h, need all 0",
               cyc, ifc.m1_ack, ifc.m0_ack, ifc.m1_rvalid, ifc.m0_rvalid, ifc.bus_wen,
               ifc.bus_addr, ifc.bus_wdata, ifc.m0_rdata, ifc.m1_rdata);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || mq[0].size() != 0 || mq[1].size() != 0 ||
            req_d[0] || req_d[1]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout cyc %0d: got %0d events pending, need 0", cyc, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: got no finish by cycle %0d, need finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;

    // Reset held 3 cycles with both masters requesting; m0 wins first.
    @(negedge clk); b = cyc;
    push_op(0, 32'h0000_0100, 32'h1111_1111, 1'b1, b + 1);
    push_op(1, 32'h0000_0200, 32'h2222_2222, 1'b1, b + 1);
    exp_ack(b + 4, 0, 32'h0000_0100, 32'h1111_1111, 1'b1);
    exp_ack(b + 6, 1, 32'h0000_0200, 32'h2222_2222, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst_n = 1'b1;
    wait_idle();

    // Single m0 write.
    b = cyc;
    push_op(0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, b + 1);
    exp_ack(b + 2, 0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1);
    wait_idle();

    // m1 read with one cycle of latency.
    b = cyc;
    push_op(1, 32'h1000_0008, 32'h0, 1'b0, b + 1);
    exp_ack(b + 2, 1, 32'h1000_0008, 32'h0, 1'b0);
    exp_rv(b + 4, 1, 32'h1234_5678);
    wait_idle();

    // Both masters continuously requesting: grants alternate starting with m0.
    b = cyc;
    for (int k = 0; k < 3; k++) begin
      push_op(0, 32'h2000_0000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b1, b + 1);
      push_op(1, 32'h3000_0000 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1, b + 1);
    end
    for (int k = 0; k < 3; k++) begin
      exp_ack(b + 2 + 4 * k, 0, 32'h2000_0000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b1);
      exp_ack(b + 4 + 4 * k, 1, 32'h3000_0000 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1);
    end
    wait_idle();

    // m1 raises req during m0's WAIT and is issued right after m0 returns to IDLE.
    b = cyc;
    push_op(0, 32'h0000_0040, 32'h0, 1'b0, b + 1);
    push_op(1, 32'h4000_0000, 32'h5555_AAAA, 1'b1, b + 3);
    exp_ack(b + 2, 0, 32'h0000_0040, 32'h0, 1'b0);
    exp_rv(b + 4, 0, 32'h0040_FFBF);
    exp_ack(b + 5, 1, 32'h4000_0000, 32'h5555_AAAA, 1'b1);
    wait_idle();

    // Back-to-back reads from m0: one read every 3 cycles.
    b = cyc;
    push_op(0, 32'h1000_0008, 32'h0, 1'b0, b + 1);
    push_op(0, 32'h0000_0080, 32'h0, 1'b0, b + 1);
    exp_ack(b + 2, 0, 32'h1000_0008, 32'h0, 1'b0);
    exp_rv(b + 4, 0, 32'h1234_5678);
    exp_ack(b + 5, 0, 32'h0000_0080, 32'h0, 1'b0);
    exp_rv(b + 7, 0, 32'h0080_FF7F);
    wait_idle();

    // Reset during WAIT aborts the read: no rvalid, FSM back in IDLE.
    b = cyc;
    push_op(1, 32'h0000_0010, 32'h0, 1'b0, b + 1);
    exp_ack(b + 2, 1, 32'h0000_0010, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.m1_rvalid || ifc.m0_rvalid || ifc.bus_wen || ifc.bus_addr != 0 ||
        dut.state_reg != ST_IDLE) begin
      errors++;
      $display("FAIL reset_in_wait: got rv %0b%0b wen %0b addr %h state %0d, need 0 0 0 0 IDLE",
               ifc.m1_rvalid, ifc.m0_rvalid, ifc.bus_wen, ifc.bus_addr, dut.state_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Recovery after the aborted read.
    b = cyc;
    push_op(0, 32'h0000_0300, 32'h3333_3333, 1'b1, b + 1);
    exp_ack(b + 2, 0, 32'h0000_0300, 32'h3333_3333, 1'b1);
    wait_idle();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: got %0d pending, need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
